enemy_fleet_ctrl: RTL and testbench
===================================

# enemy_fleet_ctrl

Sequences one row of enemy ships as a formation. Owns the shared fleet X/Y offset, march direction and step cadence, and derives the row's live extent from per-ship dead flags. Each enemy instance places itself at `fleet_x_o + index*ship_pitch_p`, `fleet_y_o`. The block also detects wave clear and landing, and issues the respawn pulse that re-arms the ships.

## Interface

Parameters:

- `num_ships_p`, 8: ships in the row (index 0 leftmost).
- `ship_width_p`, 40: ship width in pixels.
- `ship_height_p`, 20: ship height in pixels.
- `ship_pitch_p`, 60: column-to-column spacing.
- `start_x_p`, 100: fleet X after reset or respawn.
- `start_y_p`, 40: fleet Y after reset or respawn.
- `left_bound_p`, 10: leftmost legal pixel (inclusive).
- `right_bound_p`, 629: rightmost legal pixel (inclusive).
- `step_x_p`, 10: horizontal step.
- `step_y_p`, 10: drop per bounce.
- `land_y_p`, 440: landing line.
- `min_frames_p`, 4: step period floor.
- `frames_per_ship_p`, 3: added period per live ship.
- `respawn_frames_p`, 300: wave-clear delay (5 s at 60 Hz).

Ports:

- `clk_i`, in, 1: clock.
- `reset_i`, in, 1: synchronous, active-high reset.
- `frame_i`, in, 1: one-cycle pulse per video frame.
- `start_i`, in, 1: start/restart request (btnC).
- `dead_i`, in, `num_ships_p`: per-ship dead flags.
- `fleet_x_o`, out, 10: X of column 0 left edge.
- `fleet_y_o`, out, 10: fleet top Y.
- `dir_right_o`, out, 1: 1 = marching right.
- `step_o`, out, 1: one-cycle pulse when offsets changed.
- `respawn_o`, out, 1: one-cycle pulse that resets all enemies.
- `active_o`, out, 1: ships visible and marching.
- `game_over_o`, out, 1: fleet has landed.
- `alive_cnt_o`, out, 4: popcount of `~dead_i`.

## Operation

- **States:** IDLE, MARCH, CLEARED, OVER.
- **Reset values:**
  - State IDLE.
  - `fleet_x_o` = `start_x_p`, `fleet_y_o` = `start_y_p`.
  - `dir_right_o` = 1.
  - `step_o`, `respawn_o`, `active_o`, `game_over_o` = 0.
  - Frame counter 0.
- **IDLE:**
  - `start_i` → re-init offsets and direction, pulse `respawn_o`, go to MARCH.
  - `frame_i` is ignored.
- **MARCH:**
  - `active_o` = 1.
  - Period P = `min_frames_p` + `alive_cnt` × `frames_per_ship_p` (28 with all 8 alive).
  - The frame counter increments on `frame_i`.
  - A step fires on a `frame_i` with counter ≥ P−1; the counter then clears. A shrinking P therefore triggers immediately.
- **Extent:**
  - lmin = lowest live index; rmax = highest live index.
  - Left edge = x + lmin×pitch.
  - Right edge = x + rmax×pitch + width − 1.
  - All math is 11-bit unsigned; the left test is done without underflow (compare edge < `left_bound_p` + `step_x_p`).
- **Step, right:**
  - If right edge + `step_x_p` ≤ `right_bound_p`: x += `step_x_p`.
  - Otherwise (bounce): y += `step_y_p`, dir flips, x unchanged.
- **Step, left:** mirror of the right case against `left_bound_p`.
- **Landing:** after a bounce, if new y + `ship_height_p` ≥ `land_y_p` → OVER.
- **All dead:** `alive_cnt` = 0 in MARCH → CLEARED; this takes priority over a same-cycle step.
- **CLEARED:**
  - `active_o` = 0.
  - Count `respawn_frames_p` frames.
  - Then re-init offsets, pulse `respawn_o`, go to MARCH.
- **OVER:**
  - `game_over_o` = 1, `active_o` = 0; offsets are held.
  - `start_i` → re-init, pulse `respawn_o`, go to MARCH.
- **`start_i` in MARCH or CLEARED:** ignored.
- **`reset_i`:** overrides everything in any state, mid-step included.

## Timing

- `frame_i` at edge t with a step due:
  - `fleet_x_o`/`fleet_y_o`/`dir_right_o` take their new values at t+1.
  - `step_o` is high for exactly the cycle t+1.
- Extent and landing checks use `dead_i` sampled at t. A kill in the same cycle counts.
- `respawn_o` is high for the single cycle after the triggering edge, with offsets already at start values that cycle.
- `dead_i` is expected to go low within 2 cycles of `respawn_o`. During the respawn cycle and the next cycle, the all-dead check is suppressed.
- `alive_cnt_o` is combinational from `dead_i`.
- `game_over_o` is registered and asserts the cycle after the landing step.

## Structure

- Shared `enemy_pkg`: fleet state enum, `frame_rate_c` = 60, and shared `screen_right_c`/`screen_left_c` constants that the parameter defaults reference.
- Sub-module `alive_extent`: combinational priority encoder plus popcount of `~dead_i` → lmin, rmax, `alive_cnt`, `none_alive`.
- The frame divider and respawn delay share one 10-bit counter register (states are exclusive).

## Test plan

- **Reset, start, first step:** reset, pulse `start_i`, drive 28 `frame_i` → `respawn_o` 1 cycle, `step_o` once after frame 28, `fleet_x_o` 100→110.
- **Right bounce:** all alive, march → x reaches 170 after 7 steps; 8th step gives y = 50, `dir_right_o` = 0, x = 170.
- **Edge follows live ships:** kill ships 6,7 → rmax = 5; bounce at x = 290 (right edge 629); period drops to 22 frames.
- **Landing:** `land_y_p` = 80 → second bounce gives y = 60, `game_over_o` = 1 next cycle; frames ignored; `start_i` restores x = 100, y = 40.
- **Wave clear:** all `dead_i` = 1 coincident with a due step → no `step_o`, CLEARED; 300 frames later `respawn_o` pulses, MARCH, x = 100.
- **Reset mid-march:** `reset_i` asserted in MARCH at x = 150 → next cycle IDLE, x = 100, y = 40, all pulses 0.

Source files
------------

// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared enemy fleet types and screen constants
//   fleet_state_e  : formation sequencer state
//   frame_rate_c   : video frames per second
//   screen_left_c  : leftmost legal pixel (inclusive)
//   screen_right_c : rightmost legal pixel (inclusive)
package enemy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MARCH   = 2'd1,
    ST_CLEARED = 2'd2,
    ST_OVER    = 2'd3
  } fleet_state_e;

  localparam int frame_rate_c   = 60;
  localparam int screen_left_c  = 10;
  localparam int screen_right_c = 629;

endpackage

// File: rtl/alive_extent.sv
// rtl/alive_extent.sv - live-ship extent and popcount of a row of dead flags
//   dead_i       : per-ship dead flags (index 0 leftmost)
//   lmin_o       : lowest live index (0 when none alive)
//   rmax_o       : highest live index (0 when none alive)
//   alive_cnt_o  : number of live ships
//   none_alive_o : every ship is dead
module alive_extent #(
  parameter int num_ships_p = 8
) (
  input  logic [num_ships_p-1:0] dead_i,
  output logic [3:0]             lmin_o,
  output logic [3:0]             rmax_o,
  output logic [3:0]             alive_cnt_o,
  output logic                   none_alive_o
);

  always_comb begin
    lmin_o      = '0;
    rmax_o      = '0;
    alive_cnt_o = '0;
    // Scanning downward leaves the lowest live index as the last write.
    for (int i = num_ships_p - 1; i >= 0; i--) begin
      if (!dead_i[i]) lmin_o = 4'(i);
    end
    // Scanning upward leaves the highest live index as the last write.
    for (int i = 0; i < num_ships_p; i++) begin
      if (!dead_i[i]) begin
        rmax_o      = 4'(i);
        alive_cnt_o = alive_cnt_o + 4'd1;
      end
    end
  end

  assign none_alive_o = &dead_i;

endmodule

// File: rtl/enemy_fleet_ctrl.sv
// rtl/enemy_fleet_ctrl.sv - formation sequencer for one row of enemy ships
//   clk_i, reset_i : clock, synchronous active-high reset
//   frame_i        : one-cycle pulse per video frame
//   start_i        : start / restart request
//   dead_i         : per-ship dead flags
//   fleet_x_o/y_o  : fleet offset (column 0 left edge, top)
//   dir_right_o    : marching right
//   step_o         : offsets changed last edge
//   respawn_o      : re-arm all ships
//   active_o       : ships visible and marching
//   game_over_o    : fleet has landed
//   alive_cnt_o    : live ship count
module enemy_fleet_ctrl
  import enemy_pkg::*;
#(
  parameter int num_ships_p       = 8,
  parameter int ship_width_p      = 40,
  parameter int ship_height_p     = 20,
  parameter int ship_pitch_p      = 60,
  parameter int start_x_p         = 100,
  parameter int start_y_p         = 40,
  parameter int left_bound_p      = screen_left_c,
  parameter int right_bound_p     = screen_right_c,
  parameter int step_x_p          = 10,
  parameter int step_y_p          = 10,
  parameter int land_y_p          = 440,
  parameter int min_frames_p      = 4,
  parameter int frames_per_ship_p = 3,
  parameter int respawn_frames_p  = 5 * frame_rate_c
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   frame_i,
  input  logic                   start_i,
  input  logic [num_ships_p-1:0] dead_i,
  output logic [9:0]             fleet_x_o,
  output logic [9:0]             fleet_y_o,
  output logic                   dir_right_o,
  output logic                   step_o,
  output logic                   respawn_o,
  output logic                   active_o,
  output logic                   game_over_o,
  output logic [3:0]             alive_cnt_o
);

  localparam logic [10:0] pitch_c       = 11'(ship_pitch_p);
  localparam logic [10:0] width_c       = 11'(ship_width_p);
  localparam logic [10:0] height_c      = 11'(ship_height_p);
  localparam logic [10:0] left_bound_c  = 11'(left_bound_p);
  localparam logic [10:0] right_bound_c = 11'(right_bound_p);
  localparam logic [10:0] step_x11_c    = 11'(step_x_p);
  localparam logic [10:0] step_y11_c    = 11'(step_y_p);
  localparam logic [10:0] land_c        = 11'(land_y_p);
  localparam logic [9:0]  step_x_c      = 10'(step_x_p);
  localparam logic [9:0]  step_y_c      = 10'(step_y_p);
  localparam logic [9:0]  start_x_c     = 10'(start_x_p);
  localparam logic [9:0]  start_y_c     = 10'(start_y_p);
  localparam logic [9:0]  resp_last_c   = 10'(respawn_frames_p - 1);

  fleet_state_e state_q, state_d;
  logic [9:0]   x_q, x_d, y_q, y_d;
  logic         dir_q, dir_d;
  logic [9:0]   cnt_q, cnt_d;   // frame divider in MARCH, respawn delay in CLEARED
  logic         step_q, step_d;
  logic         respawn_q, respawn_d;
  logic         resp_d1_q;

  logic [3:0]   lmin, rmax, alive_cnt;
  logic         none_alive;

  alive_extent #(.num_ships_p(num_ships_p)) u_extent (
    .dead_i      (dead_i),
    .lmin_o      (lmin),
    .rmax_o      (rmax),
    .alive_cnt_o (alive_cnt),
    .none_alive_o(none_alive)
  );

  logic [10:0] left_edge, right_edge;
  logic [9:0]  period_m1;
  logic        step_due, move_ok, lands, clr_block;

  assign left_edge  = {1'b0, x_q} + 11'(lmin) * pitch_c;
  assign right_edge = {1'b0, x_q} + 11'(rmax) * pitch_c + width_c - 11'd1;
  // The left test adds the step to the bound instead of subtracting it from the edge.
  assign move_ok    = dir_q ? (right_edge + step_x11_c <= right_bound_c)
                            : !(left_edge < left_bound_c + step_x11_c);
  assign lands      = ({1'b0, y_q} + step_y11_c + height_c) >= land_c;
  assign period_m1  = 10'(min_frames_p - 1) + 10'(alive_cnt) * 10'(frames_per_ship_p);
  // ">=" rather than "==" so a period that shrinks below the count fires at once.
  assign step_due   = frame_i && (cnt_q >= period_m1);
  // Ships take up to two cycles to clear their dead flags after a respawn.
  assign clr_block  = respawn_q | resp_d1_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      x_q       <= start_x_c;
      y_q       <= start_y_c;
      dir_q     <= 1'b1;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      respawn_q <= 1'b0;
      resp_d1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      respawn_q <= respawn_d;
      resp_d1_q <= respawn_q;
    end
  end

  always_comb begin
    logic reinit;
    reinit    = 1'b0;
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    step_d    = 1'b0;
    respawn_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) reinit = 1'b1;
      end
      ST_MARCH: begin
        if (none_alive && !clr_block) begin
          state_d = ST_CLEARED;
          cnt_d   = '0;
        end else if (step_due) begin
          cnt_d = '0;
          // Without a live ship the extent is meaningless, so hold position.
          if (!none_alive) begin
            step_d = 1'b1;
            if (move_ok) begin
              x_d = dir_q ? x_q + step_x_c : x_q - step_x_c;
            end else begin
              y_d   = y_q + step_y_c;
              dir_d = ~dir_q;
              if (lands) state_d = ST_OVER;
            end
          end
        end else if (frame_i) begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      ST_CLEARED: begin
        if (frame_i) begin
          if (cnt_q >= resp_last_c) reinit = 1'b1;
          else                      cnt_d  = cnt_q + 10'd1;
        end
      end
      ST_OVER: begin
        if (start_i) reinit = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (reinit) begin
      state_d   = ST_MARCH;
      x_d       = start_x_c;
      y_d       = start_y_c;
      dir_d     = 1'b1;
      cnt_d     = '0;
      respawn_d = 1'b1;
    end
  end

  always_comb begin
    active_o    = (state_q == ST_MARCH);
    game_over_o = (state_q == ST_OVER);
    fleet_x_o   = x_q;
    fleet_y_o   = y_q;
    dir_right_o = dir_q;
    step_o      = step_q;
    respawn_o   = respawn_q;
    alive_cnt_o = alive_cnt;
  end

endmodule

// File: tb/tb_enemy_fleet_ctrl.sv
// tb/tb_enemy_fleet_ctrl.sv - directed bench for enemy_fleet_ctrl
module tb_enemy_fleet_ctrl;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       frame_i = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] dead_i = 8'h00;

  logic [9:0] fx, fy, lx, ly;
  logic       fdir, fstep, fresp, fact, fover;
  logic       ldir, lstep, lresp, lact, lover;
  logic [3:0] fcnt, lcnt;

  int n_cmp = 0;
  int n_err = 0;
  int n_steps = 0;

  always #5 clk = ~clk;

  enemy_fleet_ctrl u_main (
    .clk_i(clk), .reset_i(reset_i), .frame_i(frame_i), .start_i(start_i),
    .dead_i(dead_i), .fleet_x_o(fx), .fleet_y_o(fy), .dir_right_o(fdir),
    .step_o(fstep), .respawn_o(fresp), .active_o(fact), .game_over_o(fover),
    .alive_cnt_o(fcnt)
  );

  enemy_fleet_ctrl #(.land_y_p(80)) u_land (
    .clk_i(clk), .reset_i(reset_i), .frame_i(frame_i), .start_i(start_i),
    .dead_i(dead_i), .fleet_x_o(lx), .fleet_y_o(ly), .dir_right_o(ldir),
    .step_o(lstep), .respawn_o(lresp), .active_o(lact), .game_over_o(lover),
    .alive_cnt_o(lcnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_i = 1'b1;
      tick();
      frame_i = 1'b0;
      n_steps += int'(fstep);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    reset_i = 1'b0;
    check("rst_x", fx, 100);
    check("rst_y", fy, 40);
    check("rst_dir", fdir, 1);
    check("rst_step", fstep, 0);
    check("rst_resp", fresp, 0);
    check("rst_act", fact, 0);
    check("rst_over", fover, 0);
    check("rst_alive", fcnt, 8);

    // Frames ignored in IDLE
    frames(40);
    check("idle_x", fx, 100);
    check("idle_act", fact, 0);

    // Start and first step after 28 frames
    do_start();
    check("start_resp", fresp, 1);
    check("start_act", fact, 1);
    check("start_x", fx, 100);
    tick();
    check("resp_pulse_end", fresp, 0);
    n_steps = 0;
    frames(27);
    check("no_step_27", n_steps, 0);
    check("x_27", fx, 100);
    frames(1);
    check("step_28", fstep, 1);
    check("x_110", fx, 110);
    tick();
    check("step_one_cycle", fstep, 0);

    // Right bounce with all alive
    frames(28 * 6);
    check("x_170", fx, 170);
    check("y_40", fy, 40);
    frames(28);
    check("bounce_y", fy, 50);
    check("bounce_dir", fdir, 0);
    check("bounce_x", fx, 170);
    check("bounce_step", fstep, 1);

    // Left march to the bound, then landing on the low-landing instance
    frames(28 * 16);
    check("left_x10", lx, 10);
    check("left_y50", ly, 50);
    frames(28);
    check("land_y", ly, 60);
    check("land_over", lover, 1);
    check("land_act", lact, 0);
    check("land_dir", ldir, 1);
    check("main_y60", fy, 60);
    check("main_no_over", fover, 0);
    frames(50);
    check("over_hold_x", lx, 10);
    check("over_hold_y", ly, 60);
    check("over_no_step", lstep, 0);
    do_start();
    check("restart_resp", lresp, 1);
    check("restart_x", lx, 100);
    check("restart_y", ly, 40);
    check("restart_over", lover, 0);
    check("march_ignores_start", fresp, 0);

    // Extent follows live ships: kill 6 and 7
    do_reset();
    do_start();
    dead_i = 8'hC0;
    tick();
    check("alive_6", fcnt, 6);
    n_steps = 0;
    frames(21);
    check("p22_no_step", n_steps, 0);
    frames(1);
    check("p22_step", fstep, 1);
    check("p22_x", fx, 110);
    frames(22 * 18);
    check("ext_x290", fx, 290);
    check("ext_dir", fdir, 1);
    frames(22);
    check("ext_bounce_y", fy, 50);
    check("ext_bounce_x", fx, 290);
    check("ext_bounce_dir", fdir, 0);

    // Shrinking period fires immediately
    dead_i = 8'h00;
    do_reset();
    do_start();
    frames(10);
    dead_i = 8'hFC;
    frames(1);
    check("shrink_alive", fcnt, 2);
    check("shrink_step", fstep, 1);
    check("shrink_x", fx, 110);

    // Wave clear coincident with a due step
    dead_i = 8'h00;
    do_reset();
    do_start();
    frames(27);
    dead_i = 8'hFF;
    frames(1);
    check("clr_no_step", fstep, 0);
    check("clr_act", fact, 0);
    check("clr_x", fx, 100);
    frames(299);
    check("clr_299_resp", fresp, 0);
    check("clr_299_act", fact, 0);
    frames(1);
    check("clr_resp", fresp, 1);
    check("clr_remarch", fact, 1);
    check("clr_x100", fx, 100);
    tick();
    check("suppress_1", fact, 1);
    dead_i = 8'h00;
    tick();
    check("suppress_2", fact, 1);

    // Reset mid-march with a step due
    do_reset();
    do_start();
    frames(28 * 5);
    check("mid_x150", fx, 150);
    frames(27);
    reset_i = 1'b1;
    frame_i = 1'b1;
    tick();
    reset_i = 1'b0;
    frame_i = 1'b0;
    check("mid_rst_x", fx, 100);
    check("mid_rst_y", fy, 40);
    check("mid_rst_step", fstep, 0);
    check("mid_rst_resp", fresp, 0);
    check("mid_rst_act", fact, 0);
    check("mid_rst_dir", fdir, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
